// File: rtl/vend_credit_fsm_if.sv
// Customer-facing signal bundle of the vending credit controller.
// master drives coins and cancel; slave is the controller.
interface vend_credit_fsm_if #(
  parameter int CREDIT_W = 4,
  parameter int LEVEL_W  = 2
);
  logic                coin_valid;
  logic [CREDIT_W-1:0] coin_value;
  logic                cancel;
  logic [CREDIT_W-1:0] credit;
  logic [LEVEL_W-1:0]  level;
  logic                dispense;
  logic                change_valid;
  logic [CREDIT_W-1:0] change;
  logic                coin_reject;
  logic                busy;

  modport master (
    output coin_valid, coin_value, cancel,
    input  credit, level, dispense, change_valid, change, coin_reject, busy
  );

  modport slave (
    input  coin_valid, coin_value, cancel,
    output credit, level, dispense, change_valid, change, coin_reject, busy
  );
endinterface

// File: rtl/vend_credit_fsm.sv
// Coin-credit vending controller: accumulates saturating credit, dispenses at PRICE,
// returns change or refunds on cancel, and rejects coins that cannot be taken.
module vend_credit_fsm #(
  parameter int CREDIT_W        = 4,
  parameter int LEVEL_W         = 2,
  parameter int PRICE           = 7,
  parameter int DISPENSE_CYCLES = 2,
  parameter int SAT_MODE        = 0
) (
  input  logic              clk,
  input  logic              reset,
  vend_credit_fsm_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int CNT_W = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  localparam logic [CREDIT_W-1:0] CREDIT_MAX = {CREDIT_W{1'b1}};
  localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
  localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(DISPENSE_CYCLES - 1);
  localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);
  localparam logic [LEVEL_W-1:0]  LEVEL_OVER = (SAT_MODE != 0) ? {LEVEL_W{1'b1}} : {LEVEL_W{1'b0}};

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic [CREDIT_W-1:0] change_q, change_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;

  logic                coin_seen;
  logic [CREDIT_W:0]   sum_wide;
  logic [CREDIT_W-1:0] sum_sat;
  logic [LEVEL_W-1:0]  level_s;

  // Next-state, credit and strobe computation.
  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    cnt_d          = cnt_q;
    dispense_d     = 1'b0;
    change_valid_d = 1'b0;
    change_d       = {CREDIT_W{1'b0}};
    coin_reject_d  = 1'b0;

    coin_seen = bus.coin_valid && (bus.coin_value != {CREDIT_W{1'b0}});
    sum_wide  = {1'b0, credit_q} + {1'b0, bus.coin_value};
    if (sum_wide[CREDIT_W]) begin
      sum_sat = CREDIT_MAX;
    end else begin
      sum_sat = sum_wide[CREDIT_W-1:0];
    end

    case (state_q)
      IDLE, COLLECT: begin
        if (bus.cancel && (state_q == COLLECT)) begin
          state_d        = REFUND;
          change_valid_d = 1'b1;
          change_d       = credit_q;
          coin_reject_d  = coin_seen;
        end else if (coin_seen && bus.cancel) begin
          // A coin offered together with cancel is never kept.
          coin_reject_d = 1'b1;
        end else if (coin_seen) begin
          credit_d = sum_sat;
          if (sum_sat >= PRICE_C) begin
            state_d    = VEND;
            dispense_d = 1'b1;
            cnt_d      = CNT_INIT;
          end else begin
            state_d = COLLECT;
          end
        end else begin
          state_d = state_q;
        end
      end
      VEND: begin
        coin_reject_d = coin_seen;
        if (cnt_q != {CNT_W{1'b0}}) begin
          cnt_d      = cnt_q - CNT_ONE;
          dispense_d = 1'b1;
        end else begin
          state_d  = IDLE;
          credit_d = {CREDIT_W{1'b0}};
          if (credit_q > PRICE_C) begin
            change_valid_d = 1'b1;
            change_d       = credit_q - PRICE_C;
          end else begin
            change_valid_d = 1'b0;
          end
        end
      end
      REFUND: begin
        coin_reject_d = coin_seen;
        credit_d      = {CREDIT_W{1'b0}};
        state_d       = IDLE;
      end
      default: begin
        state_d  = IDLE;
        credit_d = {CREDIT_W{1'b0}};
      end
    endcase

    busy_d = (state_d == VEND) || (state_d == REFUND);
  end

  // State and registered outputs; reset abandons any vend or refund in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      credit_q       <= {CREDIT_W{1'b0}};
      cnt_q          <= {CNT_W{1'b0}};
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_q       <= {CREDIT_W{1'b0}};
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      cnt_q          <= cnt_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      change_q       <= change_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
    end
  end

  // Display level: low credit bits when they fit, otherwise the out-of-range code.
  always_comb begin
    if (credit_q[CREDIT_W-1:LEVEL_W] == {(CREDIT_W-LEVEL_W){1'b0}}) begin
      level_s = credit_q[LEVEL_W-1:0];
    end else begin
      level_s = LEVEL_OVER;
    end
  end

  assign bus.credit       = credit_q;
  assign bus.level        = level_s;
  assign bus.dispense     = dispense_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change       = change_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = busy_q;

endmodule
